// File: rtl/byte_stream_packer.sv
// Packs a narrow LSB-first beat stream into wide words, with a pack register
// feeding an output register that is drained by a ready/valid consumer.
module byte_stream_packer #(
   parameter int DATA_IN_WIDTH  = 8,
   parameter int DATA_OUT_WIDTH = 512,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clear_i,
   input  logic                      in_valid_i,
   input  logic [DATA_IN_WIDTH-1:0]  in_data_i,
   input  logic                      in_last_i,
   output logic                      in_ready_o,
   output logic                      out_valid_o,
   output logic [DATA_OUT_WIDTH-1:0] out_data_o,
   output logic                      out_last_o,
   input  logic                      out_ready_i,
   output logic                      overflow_o,
   output logic [COUNT_WIDTH-1:0]    word_count_o
);

   localparam int RATIO = DATA_OUT_WIDTH / DATA_IN_WIDTH;
   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

   logic [CNT_W-1:0]          cnt;
   logic [DATA_OUT_WIDTH-1:0] pack;
   logic                      pack_full;
   logic                      pack_last;

   logic                      accept;
   logic                      complete;
   logic                      out_free;
   logic                      xfer;
   logic [DATA_OUT_WIDTH-1:0] merged;

   assign in_ready_o = !pack_full;
   assign accept     = in_valid_i && in_ready_o;
   assign complete   = accept && ((cnt == CNT_MAX) || in_last_i);
   assign out_free   = !out_valid_o || out_ready_i;
   assign xfer       = out_valid_o && out_ready_i;

   // Pack register with the current beat dropped into its lane.
   // NOTE: default assigned first so no path leaves merged unassigned (no latch).
   always_comb begin
      merged = pack;
      merged[int'(cnt) * DATA_IN_WIDTH +: DATA_IN_WIDTH] = in_data_i;
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt          <= '0;
         pack         <= '0;
         pack_full    <= 1'b0;
         pack_last    <= 1'b0;
         out_valid_o  <= 1'b0;
         out_data_o   <= '0;
         out_last_o   <= 1'b0;
         overflow_o   <= 1'b0;
         word_count_o <= '0;
      end else begin
         if (xfer) begin
            word_count_o <= word_count_o + COUNT_WIDTH'(1);
         end

         if (clear_i) begin
            cnt         <= '0;
            pack        <= '0;
            pack_full   <= 1'b0;
            pack_last   <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            overflow_o  <= 1'b0;
         end else begin
            if (in_valid_i && !in_ready_o) begin
               overflow_o <= 1'b1;
            end

            if (xfer) begin
               out_valid_o <= 1'b0;
            end

            if (pack_full) begin
               // Held word moves out as soon as the output register frees up.
               if (out_free) begin
                  out_data_o  <= pack;
                  out_last_o  <= pack_last;
                  out_valid_o <= 1'b1;
                  pack        <= '0;
                  pack_full   <= 1'b0;
                  pack_last   <= 1'b0;
               end
            end else if (complete) begin
               cnt <= '0;
               if (out_free) begin
                  out_data_o  <= merged;
                  out_last_o  <= in_last_i;
                  out_valid_o <= 1'b1;
                  pack        <= '0;
               end else begin
                  pack      <= merged;
                  pack_full <= 1'b1;
                  pack_last <= in_last_i;
               end
            end else if (accept) begin
               pack <= merged;
               cnt  <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_byte_stream_packer.sv
// Directed self-checking bench for byte_stream_packer with 8-bit beats packed
// into 32-bit words.
module tb_byte_stream_packer;

   localparam int DIN  = 8;
   localparam int DOUT = 32;
   localparam int CW   = 16;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            clear_i;
   logic            in_valid_i;
   logic [DIN-1:0]  in_data_i;
   logic            in_last_i;
   logic            in_ready_o;
   logic            out_valid_o;
   logic [DOUT-1:0] out_data_o;
   logic            out_last_o;
   logic            out_ready_i;
   logic            overflow_o;
   logic [CW-1:0]   word_count_o;

   int tests = 0;
   int fails = 0;

   byte_stream_packer #(
      .DATA_IN_WIDTH (DIN),
      .DATA_OUT_WIDTH(DOUT),
      .COUNT_WIDTH   (CW)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .in_last_i   (in_last_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .out_ready_i (out_ready_i),
      .overflow_o  (overflow_o),
      .word_count_o(word_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic last);
      in_valid_i = 1'b1;
      in_data_i  = d;
      in_last_i  = last;
      tick();
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
   endtask

   initial begin
      rst_i       = 1'b0;
      clear_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      in_last_i   = 1'b0;
      out_ready_i = 1'b1;

      // Reset values, before any clock edge
      #3;
      check("rst_out_valid", 32'(out_valid_o), 32'h0);
      check("rst_out_data", out_data_o, 32'h0);
      check("rst_out_last", 32'(out_last_o), 32'h0);
      check("rst_overflow", 32'(overflow_o), 32'h0);
      check("rst_word_count", 32'(word_count_o), 32'h0);
      check("rst_in_ready", 32'(in_ready_o), 32'h1);
      #5 rst_i = 1'b1;
      tick();

      // Full word, consumer ready
      for (int b = 1; b <= 4; b++) beat(8'(b), 1'b0);
      check("w1_valid", 32'(out_valid_o), 32'h1);
      check("w1_data", out_data_o, 32'h04030201);
      check("w1_last", 32'(out_last_o), 32'h0);
      tick();
      check("w1_count", 32'(word_count_o), 32'h1);
      check("w1_valid_drop", 32'(out_valid_o), 32'h0);

      // Stray in_last without valid is ignored; then a short frame
      in_last_i = 1'b1;
      tick();
      in_last_i = 1'b0;
      beat(8'hAA, 1'b0);
      beat(8'hBB, 1'b1);
      check("w2_data", out_data_o, 32'h0000BBAA);
      check("w2_last", 32'(out_last_o), 32'h1);
      tick();
      check("w2_count", 32'(word_count_o), 32'h2);

      // Stalled consumer: second word backs up into the pack register
      out_ready_i = 1'b0;
      for (int b = 0; b < 4; b++) beat(8'(8'h10 + b), 1'b0);
      check("w3_data_lane0", out_data_o, 32'h13121110);
      check("w3_valid", 32'(out_valid_o), 32'h1);
      for (int b = 4; b < 8; b++) beat(8'(8'h10 + b), 1'b0);
      check("stall_hold_data", out_data_o, 32'h13121110);
      check("stall_in_ready", 32'(in_ready_o), 32'h0);

      // Overflow beat is dropped
      in_valid_i = 1'b1;
      in_data_i  = 8'h5A;
      tick();
      in_valid_i = 1'b0;
      check("ovf_set", 32'(overflow_o), 32'h1);
      check("ovf_hold_data", out_data_o, 32'h13121110);
      tick();
      check("ovf_sticky", 32'(overflow_o), 32'h1);

      // Release the consumer
      out_ready_i = 1'b1;
      tick();
      check("w4_data", out_data_o, 32'h17161514);
      check("w4_valid", 32'(out_valid_o), 32'h1);
      check("w4_count", 32'(word_count_o), 32'h3);
      check("w4_in_ready", 32'(in_ready_o), 32'h1);
      tick();
      check("w4_count2", 32'(word_count_o), 32'h4);
      check("w4_valid_drop", 32'(out_valid_o), 32'h0);
      check("ovf_still", 32'(overflow_o), 32'h1);

      // Clear mid-word
      beat(8'h31, 1'b0);
      beat(8'h32, 1'b0);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("clr_valid", 32'(out_valid_o), 32'h0);
      check("clr_overflow", 32'(overflow_o), 32'h0);
      check("clr_in_ready", 32'(in_ready_o), 32'h1);
      check("clr_count", 32'(word_count_o), 32'h4);
      for (int b = 1; b <= 4; b++) beat(8'(8'h20 + b), 1'b0);
      check("w5_data", out_data_o, 32'h24232221);
      check("w5_valid", 32'(out_valid_o), 32'h1);
      tick();
      check("w5_count", 32'(word_count_o), 32'h5);

      // Async reset while a word is held
      out_ready_i = 1'b0;
      for (int b = 1; b <= 8; b++) beat(8'(8'h40 + b), 1'b0);
      check("held_in_ready", 32'(in_ready_o), 32'h0);
      #2 rst_i = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid_o), 32'h0);
      check("arst_in_ready", 32'(in_ready_o), 32'h1);
      check("arst_count", 32'(word_count_o), 32'h0);
      check("arst_data", out_data_o, 32'h0);
      rst_i = 1'b1;
      out_ready_i = 1'b1;
      tick();
      check("post_rst_in_ready", 32'(in_ready_o), 32'h1);
      for (int b = 1; b <= 4; b++) beat(8'(8'h50 + b), 1'b0);
      check("w6_data", out_data_o, 32'h54535251);
      tick();
      check("w6_count", 32'(word_count_o), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
